// File: rtl/alu_op_issuer.sv
// ALU operation issuer: decodes ALUOp/Funct3/Funct7, registers {Operation, SrcA, SrcB},
// and issues through a valid/ready handshake with a main+skid buffer. Optional: ALU_OP_ILLEGAL_DETECT_EN.
module alu_op_issuer #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               ALUOp,
  input  logic [2:0]               Funct3,
  input  logic [6:0]               Funct7,
  input  logic [DATA_WIDTH-1:0]    SrcA_in,
  input  logic [DATA_WIDTH-1:0]    SrcB_in,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB
`ifdef ALU_OP_ILLEGAL_DETECT_EN
  ,
  output logic                     illegal_op,
  output logic [15:0]              illegal_count
`endif
);

  localparam logic [OPCODE_LENGTH-1:0] OP_ADD     = 4'b0010;
  localparam logic [OPCODE_LENGTH-1:0] OP_SUB     = 4'b0110;
  localparam logic [OPCODE_LENGTH-1:0] OP_AND     = 4'b0000;
  localparam logic [OPCODE_LENGTH-1:0] OP_OR      = 4'b0001;
  localparam logic [OPCODE_LENGTH-1:0] OP_XOR     = 4'b0011;
  localparam logic [OPCODE_LENGTH-1:0] OP_BEQ     = 4'b1000;
  localparam logic [OPCODE_LENGTH-1:0] OP_BNE     = 4'b1001;
  localparam logic [OPCODE_LENGTH-1:0] OP_BGE     = 4'b1010;
  localparam logic [OPCODE_LENGTH-1:0] OP_BLT     = 4'b1011;
  localparam logic [OPCODE_LENGTH-1:0] OP_ILLEGAL = 4'b1111;

  typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} state_t;

  function automatic logic [OPCODE_LENGTH-1:0] decode_op(
    input logic [1:0] alu_op,
    input logic [2:0] f3,
    input logic [6:0] f7
  );
    logic [OPCODE_LENGTH-1:0] op;
    op = OP_ILLEGAL;
    case (alu_op)
      2'b00: op = OP_ADD;
      2'b01: begin
        case (f3)
          3'b000:  op = OP_BEQ;
          3'b001:  op = OP_BNE;
          3'b100:  op = OP_BLT;
          3'b101:  op = OP_BGE;
          default: op = OP_ILLEGAL;
        endcase
      end
      2'b10: begin
        case ({f3, f7})
          {3'b000, 7'b0000000}: op = OP_ADD;
          {3'b000, 7'b0100000}: op = OP_SUB;
          {3'b111, 7'b0000000}: op = OP_AND;
          {3'b110, 7'b0000000}: op = OP_OR;
          {3'b100, 7'b0000000}: op = OP_XOR;
          default:              op = OP_ILLEGAL;
        endcase
      end
      default: begin
        case (f3)
          3'b000:  op = OP_ADD;
          3'b111:  op = OP_AND;
          3'b110:  op = OP_OR;
          3'b100:  op = OP_XOR;
          default: op = OP_ILLEGAL;
        endcase
      end
    endcase
    return op;
  endfunction

  state_t state_q, state_d;

  logic [OPCODE_LENGTH-1:0] in_op_p0;
  logic [OPCODE_LENGTH-1:0] main_op_p1, skid_op_p1;
  logic [DATA_WIDTH-1:0]    main_a_p1, main_b_p1, skid_a_p1, skid_b_p1;
  logic                     accept, issue;
  logic                     load_main, load_skid, skid_to_main;

  // Stage p0: combinational decode of the incoming bundle
  assign in_op_p0 = decode_op(ALUOp, Funct3, Funct7);

  assign in_ready  = (state_q != ST_SKID);
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid & in_ready;
  assign issue     = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  // Flush wins over everything, so no register load is requested in a flush cycle.
  always_comb begin
    state_d      = state_q;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            load_main = 1'b1;
            state_d   = ST_FULL;
          end
        end
        ST_FULL: begin
          if (issue && accept) begin
            load_main = 1'b1;
          end else if (issue) begin
            state_d = ST_EMPTY;
          end else if (accept) begin
            load_skid = 1'b1;
            state_d   = ST_SKID;
          end
        end
        ST_SKID: begin
          if (issue) begin
            skid_to_main = 1'b1;
            state_d      = ST_FULL;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Stage p1: main (output) and skid entries
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_op_p1 <= '0;
      main_a_p1  <= '0;
      main_b_p1  <= '0;
    end else if (load_main) begin
      main_op_p1 <= in_op_p0;
      main_a_p1  <= SrcA_in;
      main_b_p1  <= SrcB_in;
    end else if (skid_to_main) begin
      main_op_p1 <= skid_op_p1;
      main_a_p1  <= skid_a_p1;
      main_b_p1  <= skid_b_p1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      skid_op_p1 <= '0;
      skid_a_p1  <= '0;
      skid_b_p1  <= '0;
    end else if (load_skid) begin
      skid_op_p1 <= in_op_p0;
      skid_a_p1  <= SrcA_in;
      skid_b_p1  <= SrcB_in;
    end
  end

  assign Operation = main_op_p1;
  assign SrcA      = main_a_p1;
  assign SrcB      = main_b_p1;

`ifdef ALU_OP_ILLEGAL_DETECT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic in_ill_p0, main_ill_p1, skid_ill_p1;
  logic [15:0] ill_cnt_q;

  assign in_ill_p0 = (in_op_p0 == OP_ILLEGAL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_ill_p1 <= 1'b0;
      skid_ill_p1 <= 1'b0;
    end else begin
      if (load_main)         main_ill_p1 <= in_ill_p0;
      else if (skid_to_main) main_ill_p1 <= skid_ill_p1;
      if (load_skid)         skid_ill_p1 <= in_ill_p0;
    end
  end

  // Counts issued entries only; a flushed cycle does not issue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          ill_cnt_q <= 16'd0;
    else if (issue && !flush && main_ill_p1) ill_cnt_q <= sat_inc16(ill_cnt_q);
  end

  assign illegal_op    = main_ill_p1;
  assign illegal_count = ill_cnt_q;
`endif

endmodule

// File: doc/alu_op_issuer.md
Name: alu_op_issuer

Overview:
- Producer end of the ALU operation interface. Decodes ALUOp/Funct3/Funct7 into the 4-bit ALU Operation code and registers it together with SrcA/SrcB.
- Issues the result to the execute stage through a valid/ready handshake, with a 2-entry skid buffer for backpressure.
- Sits between the ID stage and the ALU. Operation and operand outputs connect directly to the ALU's Operation, SrcA and SrcB inputs.

Parameters:
- DATA_WIDTH, 32, operand width.
- OPCODE_LENGTH, 4, width of the Operation code (fixed encoding below; must be 4).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  decode bundle valid.
- in_ready  output  1  issuer can accept a bundle this cycle.
- ALUOp  input  2  00 load/store, 01 branch, 10 R-type, 11 I-type.
- Funct3  input  3  instruction funct3.
- Funct7  input  7  instruction funct7.
- SrcA_in  input  DATA_WIDTH  operand A.
- SrcB_in  input  DATA_WIDTH  operand B (register or immediate, already muxed).
- flush  input  1  synchronous pipeline flush.
- out_valid  output  1  Operation/SrcA/SrcB hold a valid issue.
- out_ready  input  1  ALU stage consumes the issue this cycle.
- Operation  output  OPCODE_LENGTH  ALU operation code.
- SrcA  output  DATA_WIDTH  registered operand A.
- SrcB  output  DATA_WIDTH  registered operand B.

Behaviour:
- Decode (combinational, on input side):
  - ALUOp 00 -> 0010 (ADD).
  - ALUOp 01, by Funct3: 000->1000 (BEQ), 001->1001 (BNE), 100->1011 (BLT), 101->1010 (BGE), other->1111.
  - ALUOp 10, by Funct3/Funct7:
    - 000 with Funct7 0000000 -> 0010 (ADD).
    - 000 with Funct7 0100000 -> 0110 (SUB).
    - 111->0000 (AND), 110->0001 (OR), 100->0011 (XOR).
    - 111/110/100 require Funct7 0000000.
    - All other combinations -> 1111.
  - ALUOp 11, by Funct3 (Funct7 ignored): 000->0010, 111->0000, 110->0001, 100->0011, other->1111.
  - 1111 is the illegal code; the ALU yields result 0 for it.
- Storage: main register (drives outputs) plus one skid register. Each entry holds {Operation, SrcA, SrcB}.
- Handshakes:
  - Accept = in_valid & in_ready.
  - Issue = out_valid & out_ready.
- State machine:
  - EMPTY: out_valid=0, in_ready=1. Accept -> load main -> FULL.
  - FULL: out_valid=1, in_ready=1.
    - Issue & accept: load main with new bundle, stay FULL.
    - Issue only: -> EMPTY.
    - Accept only: load skid -> SKID.
    - Neither: hold.
  - SKID: out_valid=1, in_ready=0.
    - Issue: move skid to main -> FULL.
    - Otherwise hold.
- in_ready = (state != SKID). It is a combinational function of the state register only, never of out_ready.
- Latency: accept in cycle N -> out_valid with that bundle in cycle N+1 (from EMPTY).
- Throughput: 1 issue/cycle with out_ready held high.
- Ordering: strictly FIFO. The skid entry is never issued before the main entry.
- Output hold: while out_valid=1 and out_ready=0, Operation/SrcA/SrcB stay stable.
- Flush:
  - Next state EMPTY; out_valid=0 next cycle.
  - Any same-cycle accept is discarded (flush dominates in_valid and out_ready).
  - Output data registers are left unchanged.
- Reset (reset=0, asynchronous): state EMPTY, out_valid=0, Operation=0000, SrcA=0, SrcB=0, skid cleared. in_ready=1 during and after reset.
- Reset mid-transfer drops all pending entries with no partial issue.

Optional Feature:
- Macro: ALU_OP_ILLEGAL_DETECT_EN.
- With the macro defined:
  - Extra output illegal_op (1), registered alongside each entry. It is 1 when the issued Operation is 1111 and follows the same skid/main path.
  - Extra output illegal_count (16), incremented once per issued (not accepted) illegal entry. It saturates at 16'hFFFF.
  - Both outputs reset to 0; flush does not clear illegal_count.
- Without the macro: neither port exists and illegal bundles issue silently as 1111.

Test Plan:
- Reset release, ALUOp=10 Funct3=000 Funct7=0000000 SrcA=5 SrcB=3, out_ready=1 -> next cycle out_valid=1, Operation=0010, SrcA=5, SrcB=3; then out_valid=0.
- Back-to-back R-type SUB (Funct7=0100000), AND, XOR with out_ready=1 -> Operation 0110, 0000, 0011 on three consecutive cycles, no bubbles.
- out_ready=0, two accepts (BEQ, then BGE Funct3=101) -> in_ready=0 after the second. Main holds 1000 stable. Raise out_ready -> issues 1000 then 1010, in_ready=1 again.
- Flush in the SKID state with in_valid=1 -> next cycle out_valid=0, in_ready=1. Neither pending nor new bundle is ever issued.
- ALUOp=11 Funct3=010 -> Operation=1111. With ALU_OP_ILLEGAL_DETECT_EN: illegal_op=1 and illegal_count goes 0->1 on issue.
- Assert reset asynchronously mid-cycle while in FULL -> out_valid=0 and Operation=0000 immediately, without waiting for a clock edge.
